// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with level count, threshold flags, sticky errors, flush and optional FWFT
module sync_fifo_flags #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  flush_en, wr_acc, rd_acc, ovf_set, unf_set;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (int'(count_q) >= AF_LEVEL);
  assign almost_empty = (int'(count_q) <= AE_LEVEL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush outranks both requests: a colliding write is dropped silently.
  assign flush_en = cs & flush;
  assign wr_acc   = cs & wr_en & ~full  & ~flush_en;
  assign rd_acc   = cs & rd_en & ~empty & ~flush_en;
  assign ovf_set  = cs & wr_en & full   & ~flush_en;
  assign unf_set  = cs & rd_en & empty  & ~flush_en;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = ovf_set | (overflow_q  & ~(cs & err_clr));
    underflow_d = unf_set | (underflow_q & ~(cs & err_clr));
    if (flush_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      always_comb dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
      always_ff @(posedge clk) begin
        if (reset) dout_q <= '0;
        else       dout_q <= dout_d;
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed bench for sync_fifo_flags (depth 8, depth 6, FWFT variants)
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        reset, cs, wr_en, rd_en, flush, err_clr;
  logic [31:0] data_in;

  logic [31:0] a_dout, b_dout, c_dout;
  logic        a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic        b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic        c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
  logic [3:0]  a_count, c_count;
  logic [2:0]  b_count;
  logic [3:0]  a_flags;

  int nvec = 0;
  int nerr = 0;

  assign a_flags = {a_full, a_empty, a_af, a_ae};

  always #5 clk = ~clk;

  sync_fifo_flags #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .FWFT(0)) u_a (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .err_clr(err_clr), .data_in(data_in), .data_out(a_dout), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf));

  sync_fifo_flags #(.FIFO_DEPTH(6), .DATA_WIDTH(32), .FWFT(0)) u_b (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .err_clr(err_clr), .data_in(data_in), .data_out(b_dout), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf));

  sync_fifo_flags #(.FIFO_DEPTH(8), .DATA_WIDTH(32), .FWFT(1)) u_c (
    .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .flush(flush),
    .err_clr(err_clr), .data_in(data_in), .data_out(c_dout), .full(c_full), .empty(c_empty),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count), .overflow(c_ovf), .underflow(c_unf));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cs = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
    data_in = '0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++; if (a_count !== 4'd0) begin nerr++; $display("FAIL reset_count got %0d want 0", a_count); end
    nvec++; if (a_flags !== 4'b0101) begin nerr++; $display("FAIL reset_flags got %b want 0101", a_flags); end
    nvec++; if ({a_ovf, a_unf} !== 2'b00) begin nerr++; $display("FAIL reset_err got %b want 00", {a_ovf, a_unf}); end
    nvec++; if (a_dout !== 32'h0) begin nerr++; $display("FAIL reset_dout got %h want 0", a_dout); end
    nvec++; if (c_dout !== 32'h0) begin nerr++; $display("FAIL reset_fwft_dout got %h want 0", c_dout); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_flags;
    do_reset();
    wr_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_in = 32'(i);
      cyc();
      exp_flags = {i == 8, 1'b0, i >= 6, i <= 2};
      nvec++; if (a_count !== 4'(i)) begin nerr++; $display("FAIL fill_count got %0d want %0d", a_count, i); end
      nvec++; if (a_flags !== exp_flags) begin nerr++; $display("FAIL fill_flags got %b want %b", a_flags, exp_flags); end
    end
    data_in = 32'd9;
    cyc();
    wr_en = 1'b0;
    nvec++; if (a_count !== 4'd8) begin nerr++; $display("FAIL fill_ovf_count got %0d want 8", a_count); end
    nvec++; if (a_ovf !== 1'b1) begin nerr++; $display("FAIL fill_ovf got %b want 1", a_ovf); end
  endtask

  task automatic test_drain();
    logic [3:0] exp_flags;
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp_flags = {1'b0, i == 8, (8 - i) >= 6, (8 - i) <= 2};
      nvec++; if (a_dout !== 32'(i)) begin nerr++; $display("FAIL drain_dout got %h want %h", a_dout, 32'(i)); end
      nvec++; if (a_flags !== exp_flags) begin nerr++; $display("FAIL drain_flags got %b want %b", a_flags, exp_flags); end
    end
    nvec++; if (a_unf !== 1'b0) begin nerr++; $display("FAIL drain_unf_early got %b want 0", a_unf); end
    cyc();
    rd_en = 1'b0;
    nvec++; if (a_unf !== 1'b1) begin nerr++; $display("FAIL drain_unf got %b want 1", a_unf); end
    nvec++; if (a_dout !== 32'h8) begin nerr++; $display("FAIL drain_hold got %h want 8", a_dout); end
    nvec++; if (a_ovf !== 1'b1) begin nerr++; $display("FAIL drain_ovf_sticky got %b want 1", a_ovf); end
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    nvec++; if ({a_ovf, a_unf} !== 2'b00) begin nerr++; $display("FAIL err_clr got %b want 00", {a_ovf, a_unf}); end
    cs = 1'b0; wr_en = 1'b1; data_in = 32'hFFFF_0000;
    cyc();
    cs = 1'b1; wr_en = 1'b0;
    nvec++; if (a_count !== 4'd0) begin nerr++; $display("FAIL cs_gate got %0d want 0", a_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin data_in = 32'h10 + 32'(k); cyc(); end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      nvec++; if (b_dout !== 32'h10 + 32'(k)) begin nerr++; $display("FAIL wrap_rd1 got %h want %h", b_dout, 32'h10 + 32'(k)); end
    end
    rd_en = 1'b0; wr_en = 1'b1;
    for (int k = 0; k < 5; k++) begin data_in = 32'h14 + 32'(k); cyc(); end
    wr_en = 1'b0;
    nvec++; if ({b_full, b_count} !== {1'b1, 3'd6}) begin nerr++; $display("FAIL wrap_full got %b/%0d want 1/6", b_full, b_count); end
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      nvec++; if (b_dout !== 32'h13 + 32'(k)) begin nerr++; $display("FAIL wrap_rd2 got %h want %h", b_dout, 32'h13 + 32'(k)); end
    end
    rd_en = 1'b0;
    nvec++; if (b_empty !== 1'b1) begin nerr++; $display("FAIL wrap_empty got %b want 1", b_empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_en = 1'b1;
    for (int k = 0; k < 3; k++) begin data_in = 32'h100 + 32'(k); cyc(); end
    rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in = 32'h103 + 32'(k);
      cyc();
      nvec++; if (a_dout !== 32'h100 + 32'(k)) begin nerr++; $display("FAIL b2b_dout got %h want %h", a_dout, 32'h100 + 32'(k)); end
      nvec++; if (a_count !== 4'd3) begin nerr++; $display("FAIL b2b_count got %0d want 3", a_count); end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    nvec++; if ({a_ovf, a_unf} !== 2'b00) begin nerr++; $display("FAIL b2b_err got %b want 00", {a_ovf, a_unf}); end
  endtask

  task automatic test_fwft();
    do_reset();
    wr_en = 1'b1; data_in = 32'hA5A5_A5A5;
    cyc();
    wr_en = 1'b0;
    nvec++; if (c_dout !== 32'hA5A5_A5A5) begin nerr++; $display("FAIL fwft_show got %h want a5a5a5a5", c_dout); end
    cyc();
    nvec++; if ({c_empty, c_dout} !== {1'b0, 32'hA5A5_A5A5}) begin nerr++; $display("FAIL fwft_hold got %b/%h want 0/a5a5a5a5", c_empty, c_dout); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    nvec++; if ({c_empty, c_dout} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL fwft_pop got %b/%h want 1/0", c_empty, c_dout); end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 32'h5A5A_5A5A;
    cyc();
    rd_en = 1'b0; data_in = 32'h1234_5678;
    nvec++; if ({c_unf, c_count} !== {1'b1, 4'd1}) begin nerr++; $display("FAIL fwft_rw_empty got %b/%0d want 1/1", c_unf, c_count); end
    nvec++; if (c_dout !== 32'h5A5A_5A5A) begin nerr++; $display("FAIL fwft_rw_dout got %h want 5a5a5a5a", c_dout); end
    cyc();
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    nvec++; if (c_dout !== 32'h1234_5678) begin nerr++; $display("FAIL fwft_next got %h want 12345678", c_dout); end
  endtask

  task automatic test_flush();
    do_reset();
    wr_en = 1'b1;
    for (int k = 0; k < 9; k++) begin data_in = 32'h200 + 32'(k); cyc(); end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int k = 0; k < 3; k++) cyc();
    rd_en = 1'b0;
    nvec++; if ({a_ovf, a_count} !== {1'b1, 4'd5}) begin nerr++; $display("FAIL flush_pre got %b/%0d want 1/5", a_ovf, a_count); end
    flush = 1'b1; wr_en = 1'b1; data_in = 32'hDEAD_BEEF;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    nvec++; if ({a_count, a_flags} !== {4'd0, 4'b0101}) begin nerr++; $display("FAIL flush_state got %0d/%b want 0/0101", a_count, a_flags); end
    nvec++; if ({a_ovf, a_unf} !== 2'b10) begin nerr++; $display("FAIL flush_err got %b want 10", {a_ovf, a_unf}); end
    nvec++; if (a_dout !== 32'h202) begin nerr++; $display("FAIL flush_dout_hold got %h want 202", a_dout); end
    wr_en = 1'b1; data_in = 32'h77;
    cyc();
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    nvec++; if ({a_empty, a_dout} !== {1'b1, 32'h77}) begin nerr++; $display("FAIL flush_after got %b/%h want 1/77", a_empty, a_dout); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1'b1;
    for (int k = 0; k < 9; k++) begin data_in = 32'h300 + 32'(k); cyc(); end
    wr_en = 1'b0; rd_en = 1'b1;
    cyc();
    nvec++; if ({a_ovf, a_dout} !== {1'b1, 32'h300}) begin nerr++; $display("FAIL mid_pre got %b/%h want 1/300", a_ovf, a_dout); end
    wr_en = 1'b1; data_in = 32'h3FF; reset = 1'b1;
    cyc();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    nvec++; if ({a_count, a_flags} !== {4'd0, 4'b0101}) begin nerr++; $display("FAIL mid_state got %0d/%b want 0/0101", a_count, a_flags); end
    nvec++; if ({a_ovf, a_unf, a_dout} !== {2'b00, 32'h0}) begin nerr++; $display("FAIL mid_out got %b/%h want 00/0", {a_ovf, a_unf}, a_dout); end
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    nvec++; if ({a_unf, a_dout} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL mid_lost got %b/%h want 1/0", a_unf, a_dout); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_fwft();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
- Parametrised synchronous FIFO, next generation of the team's single-clock FIFO buffer.
- Depth need not be a power of two.
- Adds:
  - fill-level count output
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - synchronous flush
  - compile-time first-word-fall-through (FWFT) read mode
- Sits between a producer and a consumer in the same clock domain, e.g. buffering in front of a bus slave or streaming datapath.

Parameters:
- FIFO_DEPTH, 8, number of entries; any integer >= 2.
- DATA_WIDTH, 32, width of each entry in bits.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
- CW (localparam), clog2(FIFO_DEPTH+1), width of count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset; one clock; reset is synchronous and active-high.
- cs  in  1  chip select; gates wr_en, rd_en, flush and err_clr.
- wr_en  in  1  write request.
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of head word).
- flush  in  1  synchronous empty of FIFO contents.
- err_clr  in  1  clears sticky overflow/underflow.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  CW  number of stored entries.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- All state updates on rising clk. Reset has priority over everything.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0
  - data_out = 0, overflow = underflow = 0
  - empty = 1, full = 0, almost_empty = 1
  - almost_full = (AF_LEVEL == 0)
- Memory contents are not reset.
- Accept rules:
  - wr_acc = cs & wr_en & !full
  - rd_acc = cs & rd_en & !empty
  - All evaluated on pre-edge state. No write-through-when-full, no read-through-when-empty.
- Pointers: range 0..FIFO_DEPTH-1; wrap from FIFO_DEPTH-1 to 0 (explicit compare, not bit truncation).
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr advances.
- On rd_acc: rd_ptr advances.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both accepted
- Flags full, empty, almost_full, almost_empty: combinational decodes of count, so they reflect the new count in the cycle after the accepting edge.
- FWFT=0 (standard mode):
  - On rd_acc, data_out <= mem[rd_ptr], visible the cycle after the accepting edge (latency 1).
  - data_out holds its value otherwise, including after flush.
- FWFT=1 (fall-through mode):
  - data_out = mem[rd_ptr] when !empty, else 0 (combinational from registered state).
  - A written word appears on data_out the cycle after the write edge that made the FIFO non-empty.
  - rd_acc removes the head; the next word is presented in the following cycle.
- Overflow / underflow:
  - overflow <= 1 when cs & wr_en & full.
  - underflow <= 1 when cs & rd_en & empty.
  - Both sticky until reset, or until cs & err_clr.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag stays 1).
  - Rejected operations change no other state.
- Flush (cs & flush):
  - wr_ptr = rd_ptr = count = 0.
  - Takes priority over wr_en/rd_en in the same cycle; the simultaneous write is discarded and is not counted as overflow.
  - Sticky error flags are unaffected.
- Simultaneous read and write:
  - When full: only the read is accepted; overflow sets.
  - When empty: only the write is accepted; underflow sets. In FWFT=1 the new word is shown the next cycle.
- cs = 0: all requests ignored; outputs hold.
- Reset mid-operation: next cycle matches the reset state exactly; stored data is lost.

Test Plan:
- Reset then fill (DEPTH=8, WIDTH=32, FWFT=0): write 0x00000001..0x00000008 -> count steps 1..8; almost_full at count 6; full=1 after 8th write; 9th write leaves count 8 and sets overflow.
- Drain after fill: 8 reads -> data_out 0x1..0x8, each one cycle after its read edge; empty=1 after last; 9th read sets underflow; data_out holds 0x8.
- Wrap-around with DEPTH=6: 4 writes, 3 reads, 5 writes -> order preserved across the pointer wrap at 5->0; full=1 at count 6.
- Simultaneous read/write at count 3 for 10 cycles -> count stays 3; output sequence matches input delayed by 3 words; neither error flag set.
- FWFT=1: write 0xA5A5A5A5 into empty FIFO -> data_out=0xA5A5A5A5 next cycle with no read; read -> empty=1 and data_out=0 the following cycle.
- Flush with wr_en at count 5 -> count=0, empty=1, written word discarded, overflow unchanged. Assert reset mid-burst -> all outputs at reset values next cycle.
